universal_register: RTL and testbench

- Parametrised successor to the plain enable-register used across the representation-conversion datapath.
- Holds a WIDTH-bit word and supports hold, parallel load, logical, arithmetic and serial shifts, and rotates.
- Adds an autonomous serialise burst that shifts the word out LSB-first with busy/done handshake flags.
- Sits between conversion stages and at the serial I/O boundary of the design.

---
 rtl/universal_register_pkg.sv | 19 +
 rtl/universal_register_burst_counter.sv | 43 ++++
 rtl/universal_register.sv | 111 +++++++++++
 tb/tb_universal_register.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/universal_register_pkg.sv
// Shared constants for universal_register: command mode encodings and
// the burst state machine encoding.
package universal_register_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'd0;
  localparam logic [2:0] MODE_LOAD  = 3'd1;
  localparam logic [2:0] MODE_SHL   = 3'd2;
  localparam logic [2:0] MODE_SHR   = 3'd3;
  localparam logic [2:0] MODE_SRA   = 3'd4;
  localparam logic [2:0] MODE_ROL   = 3'd5;
  localparam logic [2:0] MODE_ROR   = 3'd6;
  localparam logic [2:0] MODE_BURST = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/universal_register_burst_counter.sv
// Loadable down-counter for the serialise burst. It stops at zero and
// flags zero so the controller can detect the last burst cycle.
module burst_counter #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count: load wins over decrement; decrement saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {CW{1'b0}})) begin
      cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/universal_register.sv
// WIDTH-bit universal shift register with parallel load, shifts, rotates
// and an autonomous LSB-first serialise burst with busy/done flags.
module universal_register
  import universal_register_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_load_s;
  logic             cnt_dec_s;
  logic             cnt_zero_s;
  logic [CW-1:0]    cnt_s;

  burst_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_burst_counter (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (cnt_load_s),
    .load_val_i (CW'(WIDTH - 1)),
    .dec_i      (cnt_dec_s),
    .cnt_o      (cnt_s),
    .zero_o     (cnt_zero_s)
  );

  // next-state, next-word and handshake decode
  always_comb begin
    q_d        = q_q;
    state_d    = state_q;
    done_d     = 1'b0;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          case (mode)
            MODE_HOLD:  q_d = q_q;
            MODE_LOAD:  q_d = data;
            MODE_SHL:   q_d = {q_q[WIDTH-2:0], ser_in};
            MODE_SHR:   q_d = {ser_in, q_q[WIDTH-1:1]};
            MODE_SRA:   q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            MODE_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            MODE_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
            MODE_BURST: begin
              q_d        = data;
              cnt_load_s = 1'b1;
              state_d    = ST_SHIFT;
            end
            default:    q_d = q_q;
          endcase
        end else begin
          q_d = q_q;
        end
      end
      ST_SHIFT: begin
        q_d = {ser_in, q_q[WIDTH-1:1]};
        // cnt reaching zero marks the last of the WIDTH busy cycles
        if (cnt_zero_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_SHIFT);
  end

  // state, word and flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      q_q     <= RESET_VAL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q       = q_q;
  assign ser_out = q_q[0];
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_universal_register.sv
// Directed self-checking bench for universal_register (WIDTH=8,
// RESET_VAL=8'h5A) with hand-computed expected values.
module tb_universal_register;

  localparam logic [2:0] M_HOLD  = 3'd0;
  localparam logic [2:0] M_LOAD  = 3'd1;
  localparam logic [2:0] M_SHL   = 3'd2;
  localparam logic [2:0] M_SHR   = 3'd3;
  localparam logic [2:0] M_SRA   = 3'd4;
  localparam logic [2:0] M_ROL   = 3'd5;
  localparam logic [2:0] M_ROR   = 3'd6;
  localparam logic [2:0] M_BURST = 3'd7;

  logic       clk;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic [7:0] data;
  logic       ser_in;
  logic [7:0] q;
  logic       ser_out;
  logic       busy;
  logic       done;

  int errors;
  int checks;

  universal_register #(
    .WIDTH     (8),
    .RESET_VAL (8'h5A)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .mode    (mode),
    .data    (data),
    .ser_in  (ser_in),
    .q       (q),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one edge; inputs change and outputs are sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] m, input logic [7:0] d, input logic si);
    en = 1'b1; mode = m; data = d; ser_in = si;
    step();
    en = 1'b0;
  endtask

  logic [7:0] exp_word;
  int         done_seen;

  initial begin
    errors = 0; checks = 0;
    reset = 1'b0; en = 1'b0; mode = M_HOLD; data = 8'h00; ser_in = 1'b0;
    #12;
    check_eq("rst_q", 32'(q), 32'h5A);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    check_eq("rst_ser_out", 32'(ser_out), 32'h0);
    step();
    reset = 1'b1;
    step();
    check_eq("idle_hold", 32'(q), 32'h5A);

    cmd(M_LOAD, 8'h96, 1'b0); check_eq("load_96", 32'(q), 32'h96);
    cmd(M_SHL, 8'h00, 1'b1);  check_eq("shl", 32'(q), 32'h2D);
    cmd(M_SHR, 8'h00, 1'b0);  check_eq("shr", 32'(q), 32'h16);
    cmd(M_LOAD, 8'h96, 1'b0);
    cmd(M_SRA, 8'h00, 1'b0);  check_eq("sra", 32'(q), 32'hCB);
    cmd(M_SHR, 8'h00, 1'b1);  check_eq("shr_fill1", 32'(q), 32'hE5);
    cmd(M_LOAD, 8'h81, 1'b0);
    cmd(M_ROL, 8'h00, 1'b0);  check_eq("rol", 32'(q), 32'h03);
    cmd(M_ROR, 8'h00, 1'b0);  check_eq("ror", 32'(q), 32'h81);
    cmd(M_HOLD, 8'hFF, 1'b1); check_eq("hold", 32'(q), 32'h81);
    en = 1'b0; mode = M_LOAD; data = 8'hFF;
    step();
    check_eq("en_gate", 32'(q), 32'h81);

    // asynchronous reset lands mid-cycle, well away from any edge
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_rst_q", 32'(q), 32'h5A);
    step();
    reset = 1'b1;
    step();

    // first burst: plain serialisation of 8'hB4
    exp_word = 8'hB4;
    cmd(M_BURST, exp_word, 1'b0);
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("b1_ser%0d", k), 32'(ser_out), 32'(exp_word[k]));
      check_eq($sformatf("b1_busy%0d", k), 32'(busy), 32'h1);
      check_eq($sformatf("b1_done%0d", k), 32'(done), 32'h0);
      step();
    end
    check_eq("b1_done", 32'(done), 32'h1);
    check_eq("b1_busy_end", 32'(busy), 32'h0);
    check_eq("b1_q_end", 32'(q), 32'h00);
    step();
    check_eq("b1_done_clr", 32'(done), 32'h0);

    // second burst: a LOAD in the 3rd busy cycle must be dropped
    cmd(M_BURST, exp_word, 1'b0);
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("b2_ser%0d", k), 32'(ser_out), 32'(exp_word[k]));
      if (k == 2) begin
        en = 1'b1; mode = M_LOAD; data = 8'hFF;
      end else begin
        en = 1'b0;
      end
      step();
    end
    en = 1'b0;
    check_eq("b2_done", 32'(done), 32'h1);
    check_eq("b2_q_end", 32'(q), 32'h00);

    // burst issued in the done cycle is accepted
    cmd(M_BURST, 8'h01, 1'b0);
    check_eq("b3_busy", 32'(busy), 32'h1);
    check_eq("b3_done_clr", 32'(done), 32'h0);
    check_eq("b3_q", 32'(q), 32'h01);
    check_eq("b3_ser0", 32'(ser_out), 32'h1);
    step(); step(); step();
    check_eq("b3_busy3", 32'(busy), 32'h1);
    check_eq("b3_ser3", 32'(ser_out), 32'h0);

    // reset during the 4th busy cycle aborts with no done pulse
    #2;
    reset = 1'b0;
    #1;
    check_eq("abort_busy", 32'(busy), 32'h0);
    check_eq("abort_q", 32'(q), 32'h5A);
    step();
    reset = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) done_seen++;
      step();
    end
    check_eq("abort_no_done", 32'(done_seen), 32'h0);
    check_eq("abort_idle", 32'(busy), 32'h0);
    cmd(M_LOAD, 8'h3C, 1'b0);
    check_eq("post_abort_load", 32'(q), 32'h3C);
    check_eq("post_abort_ser", 32'(ser_out), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
